// File: rtl/gemm_pkg.sv
// gemm_pkg: shared tile_bram geometry and dispatch enums for the dispatch datapath
package gemm_pkg;
  localparam int TILE_BRAM_DEPTH = 512;
  localparam int TILE_ADDR_W     = 9;
  localparam int MAN_LINE_W      = 256;
  localparam int EXP_W           = 8;
  localparam int LEN_W           = 10;
  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } disp_side_t;
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } disp_state_t;
endpackage

// File: rtl/dispatch_rd_pipe.sv
// dispatch_rd_pipe: delay line carrying read-valid and destination line alongside a BRAM read
// Ports: clk_i/rst_ni clock and async active-low reset; vld_i/addr_i read issued this cycle
// with its destination line; vld_o/addr_o same pair LAT cycles later, aligned with the
// returning BRAM data; busy_o high while any read is still in flight.
module dispatch_rd_pipe
  import gemm_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   vld_i,
  input  logic [TILE_ADDR_W-1:0] addr_i,
  output logic                   vld_o,
  output logic [TILE_ADDR_W-1:0] addr_o,
  output logic                   busy_o
);
  logic [LAT-1:0]                  vld_q;
  logic [LAT-1:0][TILE_ADDR_W-1:0] addr_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q[0]  <= vld_i;
      addr_q[0] <= addr_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end
  assign vld_o  = vld_q[LAT-1];
  assign addr_o = addr_q[LAT-1];
  assign busy_o = |vld_q;
endmodule

// File: rtl/tile_dispatch_writer.sv
// tile_dispatch_writer: executes DISPATCH by copying dispatcher_bram lines into one tile_bram side
// Ports: i_clk/i_reset_n clock and async active-low reset; i_disp_* command strobe and fields;
// i_hold stalls new source reads; o_disp_busy/done/err command status; o_src_rd_* source read
// port with i_src_*_rd_data returning SRC_RD_LAT cycles later; o_{man,exp} left/right write
// ports (addr/en/data) into tile_bram; o_exp_checksum running exponent sum.
// Build macro TILE_DISPATCH_CHECKSUM_EN enables the exponent checksum; otherwise it reads 0.
module tile_dispatch_writer
  import gemm_pkg::*;
#(
  parameter int SRC_ADDR_W = 11,
  parameter int SRC_RD_LAT = 1,
  parameter int DST_DEPTH  = 512
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_disp_en,
  input  logic [SRC_ADDR_W-1:0]  i_disp_src_addr,
  input  logic [TILE_ADDR_W-1:0] i_disp_dst_addr,
  input  logic [LEN_W-1:0]       i_disp_len,
  input  logic                   i_disp_side,
  input  logic                   i_hold,
  output logic                   o_disp_busy,
  output logic                   o_disp_done,
  output logic                   o_disp_err,
  output logic [SRC_ADDR_W-1:0]  o_src_rd_addr,
  output logic                   o_src_rd_en,
  input  logic [MAN_LINE_W-1:0]  i_src_man_rd_data,
  input  logic [EXP_W-1:0]       i_src_exp_rd_data,
  output logic [TILE_ADDR_W-1:0] o_man_left_wr_addr,
  output logic                   o_man_left_wr_en,
  output logic [MAN_LINE_W-1:0]  o_man_left_wr_data,
  output logic [TILE_ADDR_W-1:0] o_man_right_wr_addr,
  output logic                   o_man_right_wr_en,
  output logic [MAN_LINE_W-1:0]  o_man_right_wr_data,
  output logic [TILE_ADDR_W-1:0] o_left_exp_wr_addr,
  output logic                   o_left_exp_wr_en,
  output logic [EXP_W-1:0]       o_left_exp_wr_data,
  output logic [TILE_ADDR_W-1:0] o_right_exp_wr_addr,
  output logic                   o_right_exp_wr_en,
  output logic [EXP_W-1:0]       o_right_exp_wr_data,
  output logic [15:0]            o_exp_checksum
);
  disp_state_t            state_q, state_d;
  logic [SRC_ADDR_W-1:0]  src_q, src_d;
  logic [TILE_ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]       len_q, len_d, rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  disp_side_t             side_q, side_d;
  logic                   err_q, wr_en_q;
  logic [TILE_ADDR_W-1:0] wr_addr_q;
  logic [MAN_LINE_W-1:0]  man_q;
  logic [EXP_W-1:0]       exp_q;
  logic                   accept, rd_en, pv, pbusy, sel_l, sel_r;
  logic [TILE_ADDR_W-1:0] pa;
  assign accept = i_disp_en && state_q == IDLE && i_disp_len <= LEN_W'(DST_DEPTH);
  assign rd_en  = state_q == ISSUE && !i_hold;
  always_comb begin
    state_d  = state_q;
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    side_d   = side_q;
    rd_cnt_d = rd_cnt_q + LEN_W'(rd_en);
    wr_cnt_d = wr_cnt_q + LEN_W'(pv);
    case (state_q)
      IDLE: if (accept) begin
        state_d  = i_disp_len == '0 ? DONE : ISSUE;
        src_d    = i_disp_src_addr;
        dst_d    = i_disp_dst_addr;
        len_d    = i_disp_len;
        side_d   = disp_side_t'(i_disp_side);
        rd_cnt_d = '0;
        wr_cnt_d = '0;
      end
      ISSUE:   state_d = rd_en && rd_cnt_q == len_q - LEN_W'(1) ? DRAIN : ISSUE;
      DRAIN:   state_d = !pbusy && wr_cnt_q == len_q ? DONE : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      side_q    <= SIDE_LEFT;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      man_q     <= '0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      len_q     <= len_d;
      side_q    <= side_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      err_q     <= i_disp_en && !accept;
      wr_en_q   <= pv;
      wr_addr_q <= pv ? pa : '0;
      man_q     <= pv ? i_src_man_rd_data : '0;
      exp_q     <= pv ? i_src_exp_rd_data : '0;
    end
  end
  dispatch_rd_pipe #(.LAT(SRC_RD_LAT)) u_rd_pipe (
    .clk_i  (i_clk),
    .rst_ni (i_reset_n),
    .vld_i  (rd_en),
    .addr_i (dst_q + rd_cnt_q[TILE_ADDR_W-1:0]),
    .vld_o  (pv),
    .addr_o (pa),
    .busy_o (pbusy)
  );
  assign o_disp_busy   = state_q != IDLE;
  assign o_disp_done   = state_q == DONE;
  assign o_disp_err    = err_q;
  assign o_src_rd_en   = rd_en;
  assign o_src_rd_addr = rd_en ? src_q + SRC_ADDR_W'(rd_cnt_q) : '0;
  // side_q stays valid for the last write: a new command is only accepted after DONE
  assign sel_l = wr_en_q && side_q == SIDE_LEFT;
  assign sel_r = wr_en_q && side_q == SIDE_RIGHT;
  assign o_man_left_wr_en     = sel_l;
  assign o_man_left_wr_addr   = sel_l ? wr_addr_q : '0;
  assign o_man_left_wr_data   = sel_l ? man_q : '0;
  assign o_left_exp_wr_en     = sel_l;
  assign o_left_exp_wr_addr   = sel_l ? wr_addr_q : '0;
  assign o_left_exp_wr_data   = sel_l ? exp_q : '0;
  assign o_man_right_wr_en    = sel_r;
  assign o_man_right_wr_addr  = sel_r ? wr_addr_q : '0;
  assign o_man_right_wr_data  = sel_r ? man_q : '0;
  assign o_right_exp_wr_en    = sel_r;
  assign o_right_exp_wr_addr  = sel_r ? wr_addr_q : '0;
  assign o_right_exp_wr_data  = sel_r ? exp_q : '0;
`ifdef TILE_DISPATCH_CHECKSUM_EN
  logic [15:0] chk_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) chk_q <= '0;
    else if (accept) chk_q <= '0;
    else if (pv) chk_q <= chk_q + 16'(i_src_exp_rd_data);
  end
  assign o_exp_checksum = chk_q;
`else
  assign o_exp_checksum = '0;
`endif
endmodule

// File: tb/tb_tile_dispatch_writer.sv
// tb_tile_dispatch_writer: directed self-checking bench for tile_dispatch_writer (SRC_RD_LAT = 1)
module tb_tile_dispatch_writer;
  logic         i_clk = 1'b0;
  logic         i_reset_n = 1'b0;
  logic         i_disp_en = 1'b0;
  logic [10:0]  i_disp_src_addr = '0;
  logic [8:0]   i_disp_dst_addr = '0;
  logic [9:0]   i_disp_len = '0;
  logic         i_disp_side = 1'b0;
  logic         i_hold = 1'b0;
  logic         o_disp_busy, o_disp_done, o_disp_err, o_src_rd_en;
  logic [10:0]  o_src_rd_addr;
  logic [255:0] i_src_man_rd_data = '0;
  logic [7:0]   i_src_exp_rd_data = '0;
  logic [8:0]   o_man_left_wr_addr, o_man_right_wr_addr, o_left_exp_wr_addr, o_right_exp_wr_addr;
  logic         o_man_left_wr_en, o_man_right_wr_en, o_left_exp_wr_en, o_right_exp_wr_en;
  logic [255:0] o_man_left_wr_data, o_man_right_wr_data;
  logic [7:0]   o_left_exp_wr_data, o_right_exp_wr_data;
  logic [15:0]  o_exp_checksum;

  tile_dispatch_writer #(.SRC_ADDR_W(11), .SRC_RD_LAT(1), .DST_DEPTH(512)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_disp_en(i_disp_en),
    .i_disp_src_addr(i_disp_src_addr), .i_disp_dst_addr(i_disp_dst_addr),
    .i_disp_len(i_disp_len), .i_disp_side(i_disp_side), .i_hold(i_hold),
    .o_disp_busy(o_disp_busy), .o_disp_done(o_disp_done), .o_disp_err(o_disp_err),
    .o_src_rd_addr(o_src_rd_addr), .o_src_rd_en(o_src_rd_en),
    .i_src_man_rd_data(i_src_man_rd_data), .i_src_exp_rd_data(i_src_exp_rd_data),
    .o_man_left_wr_addr(o_man_left_wr_addr), .o_man_left_wr_en(o_man_left_wr_en),
    .o_man_left_wr_data(o_man_left_wr_data),
    .o_man_right_wr_addr(o_man_right_wr_addr), .o_man_right_wr_en(o_man_right_wr_en),
    .o_man_right_wr_data(o_man_right_wr_data),
    .o_left_exp_wr_addr(o_left_exp_wr_addr), .o_left_exp_wr_en(o_left_exp_wr_en),
    .o_left_exp_wr_data(o_left_exp_wr_data),
    .o_right_exp_wr_addr(o_right_exp_wr_addr), .o_right_exp_wr_en(o_right_exp_wr_en),
    .o_right_exp_wr_data(o_right_exp_wr_data),
    .o_exp_checksum(o_exp_checksum)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  int c0 = 0;
  int rel;
  int nchk = 0;
  int nerr = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Source BRAM model, one-cycle read latency
  logic [7:0] exp_mem [2048];
  function automatic logic [255:0] mk_man(input logic [10:0] a);
    return {16{5'b0, a}};
  endfunction
  always @(posedge i_clk)
    if (o_src_rd_en) begin
      i_src_man_rd_data <= mk_man(o_src_rd_addr);
      i_src_exp_rd_data <= exp_mem[o_src_rd_addr];
    end

  // Event log, cycle numbers relative to the accepting edge
  int           rd_c[$], w_c[$], d_c[$], e_c[$];
  logic [10:0]  rd_a[$];
  logic         w_s[$];
  logic [8:0]   w_a[$];
  logic [255:0] w_m[$];
  logic [7:0]   w_e[$];
  logic [15:0]  d_k[$];
  int           viol = 0;

  always @(negedge i_clk) begin
    rel = cyc - c0;
    if (o_src_rd_en) begin rd_c.push_back(rel); rd_a.push_back(o_src_rd_addr); end
    if (o_man_left_wr_en) begin
      w_c.push_back(rel); w_s.push_back(1'b0); w_a.push_back(o_man_left_wr_addr);
      w_m.push_back(o_man_left_wr_data); w_e.push_back(o_left_exp_wr_data);
    end
    if (o_man_right_wr_en) begin
      w_c.push_back(rel); w_s.push_back(1'b1); w_a.push_back(o_man_right_wr_addr);
      w_m.push_back(o_man_right_wr_data); w_e.push_back(o_right_exp_wr_data);
    end
    if (o_man_left_wr_en !== o_left_exp_wr_en || o_man_left_wr_addr !== o_left_exp_wr_addr) viol++;
    if (o_man_right_wr_en !== o_right_exp_wr_en || o_man_right_wr_addr !== o_right_exp_wr_addr) viol++;
    if (!o_man_left_wr_en && ({o_man_left_wr_addr, o_left_exp_wr_addr, o_left_exp_wr_data} !== '0 || o_man_left_wr_data !== '0)) viol++;
    if (!o_man_right_wr_en && ({o_man_right_wr_addr, o_right_exp_wr_addr, o_right_exp_wr_data} !== '0 || o_man_right_wr_data !== '0)) viol++;
    if (o_disp_done) begin d_c.push_back(rel); d_k.push_back(o_exp_checksum); end
    if (o_disp_err) e_c.push_back(rel);
  end

  task automatic clear_log();
    rd_c.delete(); rd_a.delete(); w_c.delete(); w_s.delete(); w_a.delete();
    w_m.delete(); w_e.delete(); d_c.delete(); d_k.delete(); e_c.delete();
    viol = 0;
  endtask

  // Issue one command, optionally holding cycles h_lo..h_hi and re-strobing at cycle dup_at
  task automatic run_cmd(input logic [10:0] src, input logic [8:0] dst, input logic [9:0] len,
                         input logic side, input int h_lo, input int h_hi, input int dup_at,
                         input int ncyc);
    @(posedge i_clk); #1;
    clear_log();
    i_disp_en = 1'b1; i_disp_src_addr = src; i_disp_dst_addr = dst;
    i_disp_len = len; i_disp_side = side; c0 = cyc;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge i_clk); #1;
      i_disp_en = (k == dup_at);
      i_disp_src_addr = 11'd7; i_disp_dst_addr = 9'd3; i_disp_len = 10'd5; i_disp_side = ~side;
      i_hold = (k >= h_lo && k <= h_hi);
    end
    i_disp_en = 1'b0; i_hold = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    nchk++;
    if ({o_disp_busy, o_disp_done, o_disp_err, o_src_rd_en, o_man_left_wr_en, o_man_right_wr_en,
         o_left_exp_wr_en, o_right_exp_wr_en} !== 8'h00) begin
      nerr++; $display("FAIL reset_flags: got %b expected 00000000", {o_disp_busy, o_disp_done,
        o_disp_err, o_src_rd_en, o_man_left_wr_en, o_man_right_wr_en, o_left_exp_wr_en, o_right_exp_wr_en});
    end
    nchk++;
    if ({o_src_rd_addr, o_exp_checksum} !== '0) begin
      nerr++; $display("FAIL reset_addr_chk: got %h/%h expected 0/0", o_src_rd_addr, o_exp_checksum);
    end
    @(posedge i_clk); #1 i_reset_n = 1'b1;
    @(negedge i_clk);
    nchk++;
    if (o_disp_busy !== 1'b0) begin nerr++; $display("FAIL reset_release_busy: got %b expected 0", o_disp_busy); end
  endtask

  task automatic test_basic();
    run_cmd(11'd100, 9'd10, 10'd4, 1'b0, -1, -1, -1, 16);
    nchk++;
    if (rd_c.size() != 4) begin nerr++; $display("FAIL basic_rd_count: got %0d expected 4", rd_c.size()); end
    for (int i = 0; i < 4; i++) begin
      nchk++;
      if ((i < rd_c.size() ? rd_c[i] : -1) !== i + 1 || (i < rd_a.size() ? rd_a[i] : 11'h7ff) !== 11'(100 + i)) begin
        nerr++; $display("FAIL basic_rd[%0d]: got cyc %0d addr %0d expected cyc %0d addr %0d", i,
          (i < rd_c.size() ? rd_c[i] : -1), (i < rd_a.size() ? rd_a[i] : 11'h7ff), i + 1, 100 + i);
      end
    end
    nchk++;
    if (w_c.size() != 4) begin nerr++; $display("FAIL basic_wr_count: got %0d expected 4", w_c.size()); end
    for (int i = 0; i < 4 && i < w_c.size(); i++) begin
      nchk++;
      if (w_c[i] !== i + 3 || w_s[i] !== 1'b0 || w_a[i] !== 9'(10 + i) || w_m[i] !== mk_man(11'(100 + i))
          || w_e[i] !== exp_mem[100 + i]) begin
        nerr++; $display("FAIL basic_wr[%0d]: got cyc %0d side %0d addr %0d exp %h expected cyc %0d side 0 addr %0d exp %h",
          i, w_c[i], w_s[i], w_a[i], w_e[i], i + 3, 10 + i, exp_mem[100 + i]);
      end
    end
    nchk++;
    if (d_c.size() != 1 || d_c[0] != 7) begin
      nerr++; $display("FAIL basic_done: got %0d pulses first at %0d expected 1 at 7", d_c.size(), (d_c.size() > 0 ? d_c[0] : -1));
    end
    nchk++;
    if (viol != 0 || e_c.size() != 0) begin
      nerr++; $display("FAIL basic_ports: got %0d port violations %0d errs expected 0/0", viol, e_c.size());
    end
  endtask

  task automatic test_wrap();
    run_cmd(11'd2046, 9'd510, 10'd4, 1'b1, -1, -1, -1, 16);
    nchk++;
    if (rd_c.size() != 4 || w_c.size() != 4) begin
      nerr++; $display("FAIL wrap_counts: got rd %0d wr %0d expected 4/4", rd_c.size(), w_c.size());
    end
    for (int i = 0; i < 4 && i < rd_a.size() && i < w_a.size(); i++) begin
      nchk++;
      if (rd_a[i] !== 11'(2046 + i) || w_a[i] !== 9'(510 + i) || w_s[i] !== 1'b1 || w_m[i] !== mk_man(11'(2046 + i))) begin
        nerr++; $display("FAIL wrap[%0d]: got rd %0d wr %0d side %0d expected rd %0d wr %0d side 1", i,
          rd_a[i], w_a[i], w_s[i], 11'(2046 + i), 9'(510 + i));
      end
    end
    nchk++;
    if (d_c.size() != 1 || d_c[0] != 7 || viol != 0) begin
      nerr++; $display("FAIL wrap_done: got %0d pulses viol %0d expected 1 pulse at 7 viol 0", d_c.size(), viol);
    end
  endtask

  task automatic test_hold();
    int exp_rc [6] = '{1, 2, 6, 7, 8, 9};
    run_cmd(11'd300, 9'd20, 10'd6, 1'b0, 3, 5, -1, 20);
    nchk++;
    if (rd_c.size() != 6 || w_c.size() != 6) begin
      nerr++; $display("FAIL hold_counts: got rd %0d wr %0d expected 6/6", rd_c.size(), w_c.size());
    end
    for (int i = 0; i < 6 && i < rd_c.size() && i < w_c.size(); i++) begin
      nchk++;
      if (rd_c[i] !== exp_rc[i] || rd_a[i] !== 11'(300 + i) || w_c[i] !== exp_rc[i] + 2 || w_a[i] !== 9'(20 + i)
          || w_m[i] !== mk_man(11'(300 + i))) begin
        nerr++; $display("FAIL hold[%0d]: got rd %0d@%0d wr %0d@%0d expected rd %0d@%0d wr %0d@%0d", i,
          rd_a[i], rd_c[i], w_a[i], w_c[i], 300 + i, exp_rc[i], 20 + i, exp_rc[i] + 2);
      end
    end
    nchk++;
    if (d_c.size() != 1 || d_c[0] != 12) begin
      nerr++; $display("FAIL hold_done: got %0d pulses first at %0d expected 1 at 12", d_c.size(), (d_c.size() > 0 ? d_c[0] : -1));
    end
  endtask

  task automatic test_zero_len();
    run_cmd(11'd5, 9'd5, 10'd0, 1'b0, -1, -1, -1, 8);
    nchk++;
    if (d_c.size() != 1 || d_c[0] != 1 || rd_c.size() != 0 || w_c.size() != 0) begin
      nerr++; $display("FAIL zero_len: got done %0d@%0d rd %0d wr %0d expected done 1@1 rd 0 wr 0",
        d_c.size(), (d_c.size() > 0 ? d_c[0] : -1), rd_c.size(), w_c.size());
    end
  endtask

  task automatic test_busy_err();
    run_cmd(11'd400, 9'd100, 10'd4, 1'b1, -1, -1, 2, 16);
    nchk++;
    if (e_c.size() != 1 || e_c[0] != 3) begin
      nerr++; $display("FAIL busy_err: got %0d err pulses first at %0d expected 1 at 3", e_c.size(), (e_c.size() > 0 ? e_c[0] : -1));
    end
    nchk++;
    if (d_c.size() != 1 || d_c[0] != 7 || w_c.size() != 4) begin
      nerr++; $display("FAIL busy_orig_done: got done %0d wr %0d expected done 1@7 wr 4", d_c.size(), w_c.size());
    end
    for (int i = 0; i < 4 && i < w_a.size(); i++) begin
      nchk++;
      if (w_s[i] !== 1'b1 || w_a[i] !== 9'(100 + i) || w_m[i] !== mk_man(11'(400 + i))) begin
        nerr++; $display("FAIL busy_wr[%0d]: got side %0d addr %0d expected side 1 addr %0d", i, w_s[i], w_a[i], 100 + i);
      end
    end
  endtask

  task automatic test_len_reject();
    run_cmd(11'd0, 9'd0, 10'd600, 1'b0, -1, -1, -1, 8);
    nchk++;
    if (e_c.size() != 1 || e_c[0] != 1 || d_c.size() != 0 || rd_c.size() != 0) begin
      nerr++; $display("FAIL len_reject: got err %0d done %0d rd %0d expected err 1@1 done 0 rd 0",
        e_c.size(), d_c.size(), rd_c.size());
    end
  endtask

  task automatic test_reset_mid();
    int late;
    @(posedge i_clk); #1;
    clear_log();
    i_disp_en = 1'b1; i_disp_src_addr = 11'd50; i_disp_dst_addr = 9'd30; i_disp_len = 10'd8;
    i_disp_side = 1'b0; c0 = cyc;
    @(posedge i_clk); #1 i_disp_en = 1'b0;
    repeat (3) @(posedge i_clk);
    #2 i_reset_n = 1'b0;
    #1;
    nchk++;
    if ({o_disp_busy, o_disp_done, o_src_rd_en, o_man_left_wr_en, o_left_exp_wr_en} !== 5'b0
        || o_src_rd_addr !== '0 || o_man_left_wr_data !== '0) begin
      nerr++; $display("FAIL reset_mid_outputs: got busy %b rd_en %b wr_en %b expected all 0",
        o_disp_busy, o_src_rd_en, o_man_left_wr_en);
    end
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    repeat (12) @(posedge i_clk);
    late = 0;
    foreach (w_c[i]) if (w_c[i] >= 4) late++;
    foreach (rd_c[i]) if (rd_c[i] >= 4) late++;
    nchk++;
    if (d_c.size() != 0 || late != 0) begin
      nerr++; $display("FAIL reset_mid_abort: got %0d done %0d late events expected 0/0", d_c.size(), late);
    end
    run_cmd(11'd60, 9'd40, 10'd2, 1'b1, -1, -1, -1, 10);
    nchk++;
    if (d_c.size() != 1 || d_c[0] != 5 || w_c.size() != 2) begin
      nerr++; $display("FAIL reset_mid_fresh: got done %0d wr %0d expected done 1@5 wr 2", d_c.size(), w_c.size());
    end
    for (int i = 0; i < 2 && i < w_a.size(); i++) begin
      nchk++;
      if (w_s[i] !== 1'b1 || w_a[i] !== 9'(40 + i) || w_m[i] !== mk_man(11'(60 + i))) begin
        nerr++; $display("FAIL reset_mid_wr[%0d]: got side %0d addr %0d expected side 1 addr %0d", i, w_s[i], w_a[i], 40 + i);
      end
    end
  endtask

  task automatic test_checksum();
    run_cmd(11'd700, 9'd0, 10'd3, 1'b0, -1, -1, -1, 12);
`ifdef TILE_DISPATCH_CHECKSUM_EN
    nchk++;
    if (d_k.size() != 1 || d_k[0] !== 16'h0200) begin
      nerr++; $display("FAIL checksum_done: got %h expected 0200", (d_k.size() > 0 ? d_k[0] : 16'hxxxx));
    end
    nchk++;
    if (o_exp_checksum !== 16'h0200) begin
      nerr++; $display("FAIL checksum_stable: got %h expected 0200", o_exp_checksum);
    end
`else
    nchk++;
    if (d_k.size() != 1 || d_k[0] !== 16'h0000 || o_exp_checksum !== 16'h0000) begin
      nerr++; $display("FAIL checksum_off: got %h expected 0000", o_exp_checksum);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) exp_mem[i] = 8'(i) ^ 8'h5A;
    exp_mem[700] = 8'hFF;
    exp_mem[701] = 8'hFF;
    exp_mem[702] = 8'h02;
    test_reset();
    test_basic();
    test_wrap();
    test_hold();
    test_zero_len();
    test_busy_err();
    test_len_reject();
    test_reset_mid();
    test_checksum();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
